// File: rtl/pc_sequencer_if.sv
// Fetch-stage PC sequencer bus: redirect requests in, fetch address/handshake out.
interface pc_sequencer_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [3:0]  jump_region;
  logic        redirect_pending;
  logic        err_misaligned;

  modport master (
    input  stall, redirect_valid, redirect_target, fetch_ready,
    output fetch_valid, pc, pc_plus4, jump_region, redirect_pending, err_misaligned
  );

  modport slave (
    output stall, redirect_valid, redirect_target, fetch_ready,
    input  fetch_valid, pc, pc_plus4, jump_region, redirect_pending, err_misaligned
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter owner for fetch: sequential advance, redirects (buffered across
// stalls, newest wins), misaligned-target rejection and a BOOT cycle after reset.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_sequencer_if.master  bus
);

  typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend_tgt;
  logic        r_pend;
  logic        r_fetch_valid;
  logic        r_err;

  logic        w_adv;
  logic        w_redir_ok;
  logic        w_redir_bad;
  logic [31:0] w_pc_plus4;

  assign w_adv       = r_fetch_valid & bus.fetch_ready & ~bus.stall;
  assign w_redir_ok  = bus.redirect_valid & (bus.redirect_target[1:0] == 2'b00);
  assign w_redir_bad = bus.redirect_valid & (bus.redirect_target[1:0] != 2'b00);
  assign w_pc_plus4  = r_pc + 32'd4;

  assign bus.pc               = r_pc;
  assign bus.pc_plus4         = w_pc_plus4;
  assign bus.jump_region      = w_pc_plus4[31:28];
  assign bus.fetch_valid      = r_fetch_valid;
  assign bus.redirect_pending = r_pend;
  assign bus.err_misaligned   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_pend_tgt    <= '0;
      r_pend        <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_err <= w_redir_bad;

      // fetch_valid is low only in BOOT, so adv never fires there and any
      // redirect seen in BOOT falls through to the buffering branch.
      if (w_adv) begin
        r_pend <= 1'b0;
        if (w_redir_ok)  r_pc <= bus.redirect_target;
        else if (r_pend) r_pc <= r_pend_tgt;
        else             r_pc <= w_pc_plus4;
      end else if (w_redir_ok) begin
        r_pend     <= 1'b1;
        r_pend_tgt <= bus.redirect_target;
      end

      case (r_state)
        BOOT: begin
          r_state       <= RUN;
          r_fetch_valid <= 1'b1;
        end
        RUN: begin
          if (bus.stall || !bus.fetch_ready) r_state <= STALL;
        end
        STALL: begin
          if (w_adv) r_state <= RUN;
        end
        default: r_state <= BOOT;
      endcase
    end
  end

endmodule
